fib_seq_ctrl: RTL and testbench

Command-driven sequencer that owns a step-enabled Fibonacci datapath and streams a requested number of terms to a downstream consumer. It accepts one command at a time over a valid/ready handshake and emits terms F0, F1, … over a backpressured valid/ready stream, with a last marker and a per-term overflow flag. It also supports abort and a completion pulse. It replaces free-running term generation wherever a consumer needs bounded, flow-controlled sequences.

---
 rtl/fib_pkg.sv | 16 +
 rtl/fib_step_core.sv | 61 ++++++
 rtl/fib_seq_ctrl.sv | 103 ++++++++++
 tb/tb_fib_seq_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequencer.
package fib_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 8;

    // Seed terms F0 and F1.
    localparam int A0 = 0;
    localparam int B0 = 1;

endpackage

// File: rtl/fib_step_core.sv
// Step-enabled Fibonacci datapath: a holds the current term, b the next one.
// The overflow flags follow the terms so the flag presented with a term
// reflects every wrap up to and including that term.
module fib_step_core
    import fib_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] a,
    output logic             ovf_a
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             ovf_a_q, ovf_a_d;
    logic             ovf_b_q, ovf_b_d;
    logic [WIDTH:0]   sum;

    // Next-term computation; load re-seeds and wins over step.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        ovf_a_d = ovf_a_q;
        ovf_b_d = ovf_b_q;
        sum     = {1'b0, a_q} + {1'b0, b_q};
        if (load) begin
            a_d     = WIDTH'(A0);
            b_d     = WIDTH'(B0);
            ovf_a_d = 1'b0;
            ovf_b_d = 1'b0;
        end else if (step) begin
            a_d     = b_q;
            b_d     = sum[WIDTH-1:0];
            ovf_a_d = ovf_b_q;
            ovf_b_d = ovf_a_q | ovf_b_q | sum[WIDTH];
        end
    end

    // Term and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= WIDTH'(A0);
            b_q     <= WIDTH'(B0);
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            ovf_a_q <= ovf_a_d;
            ovf_b_q <= ovf_b_d;
        end
    end

    assign a     = a_q;
    assign ovf_a = ovf_a_q;

endmodule

// File: rtl/fib_seq_ctrl.sv
// Command-driven sequencer: accepts a term count, streams that many
// Fibonacci terms over a valid/ready port, then pulses done.
// All outputs decode from registered state, so out_valid never depends
// combinationally on out_ready.
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_ovf,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             core_load;
    logic             core_step;
    logic [WIDTH-1:0] core_a;
    logic             core_ovf;

    fib_step_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (core_load),
        .step  (core_step),
        .a     (core_a),
        .ovf_a (core_ovf)
    );

    // Next-state, counter and done decode. A zero-count command is
    // acknowledged with done only; abort still honours a same-cycle transfer.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_count != '0) begin
                        core_load = 1'b1;
                        rem_d     = cmd_count;
                        state_d   = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (out_ready) begin
                    core_step = 1'b1;
                    rem_d     = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                if (cmd_abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign cmd_ready = (state_q == IDLE);
    assign out_valid = busy;
    assign out_data  = busy ? core_a : '0;
    assign out_ovf   = busy & core_ovf;
    assign out_last  = busy & (rem_q == CNT_W'(1));
    assign done      = done_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl at WIDTH=8 so the overflow case is reachable.
module tb_fib_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             cmd_abort = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ovf;
    logic             busy;
    logic             done;

    int n_chk  = 0;
    int n_fail = 0;

    // F0..F14 modulo 256; the last entry is 377 wrapped.
    logic [7:0] fib_tab [15] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                                 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121};

    fib_seq_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_count (cmd_count),
        .cmd_abort (cmd_abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ovf   (out_ovf),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command; returns positioned in the cycle after the accepting edge.
    task automatic issue(input int cnt);
        cmd_valid = 1'b1;
        cmd_count = CNT_W'(cnt);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Check n beats streamed with out_ready high; ends in the cycle after the last transfer.
    task automatic stream(input string tag, input int n, input logic ovf_last);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_data"}, out_data, fib_tab[i]);
            chk({tag, "_last"}, out_last, (i == n - 1));
            chk({tag, "_ovf"}, out_ovf, ovf_last && (i == n - 1));
            tick();
        end
    endtask

    initial begin
        int idx;
        int cyc;

        // Reset state
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 1);
        rst_n = 1'b1;
        tick();

        // Basic stream of 10 terms, then done one cycle later
        issue(10);
        chk("basic_busy", busy, 1);
        chk("basic_cmd_ready", cmd_ready, 0);
        stream("basic", 10, 1'b0);
        chk("basic_done", done, 1);
        chk("basic_idle_valid", out_valid, 0);
        chk("basic_idle_ready", cmd_ready, 1);
        tick();
        chk("basic_done_clr", done, 0);

        // Backpressure: ready pattern 1,0,0 repeating
        issue(6);
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 40) begin
            out_ready = (cyc % 3 == 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, fib_tab[idx]);
            chk("bp_last", out_last, (idx == 5));
            chk("bp_done_early", done, 0);
            if (out_ready) idx++;
            tick();
            cyc++;
        end
        chk("bp_beats", idx, 6);
        chk("bp_done", done, 1);
        chk("bp_valid_end", out_valid, 0);

        // Overflow run of 15, then back-to-back command with one bubble
        tick();
        issue(15);
        stream("ovf", 15, 1'b1);
        chk("ovf_done", done, 1);
        chk("b2b_bubble", out_valid, 0);
        issue(3);
        stream("b2b", 3, 1'b0);
        chk("b2b_done", done, 1);
        tick();

        // Zero count: done only
        issue(0);
        chk("zero_done", done, 1);
        chk("zero_valid", out_valid, 0);
        chk("zero_busy", busy, 0);
        tick();
        chk("zero_done_clr", done, 0);
        chk("zero_valid2", out_valid, 0);

        // Single beat
        issue(1);
        stream("one", 1, 1'b0);
        chk("one_done", done, 1);
        tick();

        // Abort after 5 transfers with a command held during RUN
        issue(20);
        cmd_valid = 1'b1;
        cmd_count = CNT_W'(2);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("abt_data", out_data, fib_tab[i]);
            chk("abt_cmd_ready", cmd_ready, 0);
            tick();
        end
        chk("abt_data5", out_data, fib_tab[5]);
        out_ready = 1'b0;
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("abt_valid", out_valid, 0);
        chk("abt_no_done", done, 0);
        chk("abt_ready", cmd_ready, 1);
        tick();  // held command accepted now
        cmd_valid = 1'b0;
        stream("abt_next", 2, 1'b0);
        chk("abt_next_done", done, 1);
        tick();

        // Reset mid-run
        issue(5);
        out_ready = 1'b1;
        tick();
        tick();
        chk("mid_data_pre", out_data, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_data", out_data, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_ready", cmd_ready, 1);
        #3;
        rst_n = 1'b1;
        tick();
        chk("mid_done_after", done, 0);
        issue(3);
        stream("mid_next", 3, 1'b0);
        chk("mid_next_done", done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
